// File: rtl/coresub_sramtrm_seq_if.sv
// Bus bundle between the SRAM trim SFR block, the safe-apply sequencer and the SRAM macros.
// The master modport is the SFR/macro side; the slave modport is the sequencer.
interface coresub_sramtrm_seq_if #(
  parameter int unsigned NB = 6,
  parameter int unsigned TW = 3,
  parameter int unsigned WW = 2
) ();
  logic [NB*TW-1:0] tgt_trm;
  logic [NB*WW-1:0] tgt_wait;
  logic             apply;
  logic             err_clr;
  logic [NB-1:0]    qreq;
  logic [NB-1:0]    qack;
  logic [NB*TW-1:0] trm_out;
  logic [NB*WW-1:0] wait_out;
  logic             busy;
  logic             done;
  logic [NB-1:0]    tout_err;
  logic             overrun;

  modport master (
    output tgt_trm, tgt_wait, apply, err_clr, qack,
    input  qreq, trm_out, wait_out, busy, done, tout_err, overrun
  );

  modport slave (
    input  tgt_trm, tgt_wait, apply, err_clr, qack,
    output qreq, trm_out, wait_out, busy, done, tout_err, overrun
  );
endinterface

// File: rtl/coresub_sramtrm_seq.sv
// Safe-apply sequencer: pushes SFR trim/wait targets to the SRAM banks one at a time,
// each bank only while quiesced (qreq/qack handshake, update, settle, release).
module coresub_sramtrm_seq #(
  parameter int unsigned      NB     = 6,
  parameter int unsigned      TW     = 3,
  parameter int unsigned      WW     = 2,
  parameter logic [NB*TW-1:0] TRM_IV = 18'o344244,
  parameter int unsigned      SETTLE = 8,
  parameter int unsigned      TOUT   = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  coresub_sramtrm_seq_if.slave  bus
);

  localparam int unsigned IW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CMAX = (TOUT > SETTLE) ? TOUT : SETTLE;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);
  localparam logic [CW-1:0] TOUT_M1   = CW'(TOUT - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_QREQ,
    S_APPLY,
    S_SETTLE,
    S_RELEASE
  } state_t;

  state_t                    r_state, w_state;
  logic [IW-1:0]             r_idx, w_idx;
  logic [CW-1:0]             r_cnt, w_cnt;
  logic [NB-1:0][TW-1:0]     r_sh_trm, w_sh_trm;
  logic [NB-1:0][WW-1:0]     r_sh_wait, w_sh_wait;
  logic [NB-1:0][TW-1:0]     r_trm, w_trm;
  logic [NB-1:0][WW-1:0]     r_wait, w_wait;
  logic [NB-1:0]             r_qreq, w_qreq;
  logic                      r_busy, w_busy;
  logic                      r_done, w_done;
  logic [NB-1:0]             r_tout_err, w_tout_err;
  logic                      r_overrun, w_overrun;
  logic [NB-1:0]             w_err_set;
  logic                      w_ovr_set;
  logic                      w_adv;

  // Next-state, datapath and flag logic
  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_cnt     = r_cnt;
    w_sh_trm  = r_sh_trm;
    w_sh_wait = r_sh_wait;
    w_trm     = r_trm;
    w_wait    = r_wait;
    w_qreq    = r_qreq;
    w_done    = 1'b0;
    w_err_set = '0;
    w_adv     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // An apply coinciding with the done pulse is treated as an overrun, not a restart
        if (bus.apply && !r_done) begin
          w_sh_trm  = bus.tgt_trm;
          w_sh_wait = bus.tgt_wait;
          w_idx     = '0;
          w_state   = S_SCAN;
        end
      end
      S_SCAN: begin
        if ((r_sh_trm[r_idx] == r_trm[r_idx]) && (r_sh_wait[r_idx] == r_wait[r_idx])) begin
          w_adv = 1'b1;
        end else begin
          w_qreq        = '0;
          w_qreq[r_idx] = 1'b1;
          w_cnt         = '0;
          w_state       = S_QREQ;
        end
      end
      S_QREQ: begin
        if (bus.qack[r_idx]) begin
          w_state = S_APPLY;
        end else if (r_cnt >= TOUT_M1) begin
          w_qreq           = '0;
          w_err_set[r_idx] = 1'b1;
          w_adv            = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_APPLY: begin
        w_trm[r_idx]  = r_sh_trm[r_idx];
        w_wait[r_idx] = r_sh_wait[r_idx];
        w_cnt         = '0;
        w_state       = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt >= SETTLE_M1) begin
          w_qreq  = '0;
          w_cnt   = '0;
          w_state = S_RELEASE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_RELEASE: begin
        if (!bus.qack[r_idx]) begin
          w_adv = 1'b1;
        end else if (r_cnt >= TOUT_M1) begin
          w_err_set[r_idx] = 1'b1;
          w_adv            = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_qreq  = '0;
        w_state = S_IDLE;
      end
    endcase

    // Finishing a bank either moves to the next one or closes the sequence
    if (w_adv) begin
      if (r_idx == LAST_IDX) begin
        w_state = S_IDLE;
        w_done  = 1'b1;
      end else begin
        w_idx   = r_idx + IW'(1);
        w_state = S_SCAN;
      end
    end

    w_ovr_set  = bus.apply && ((r_state != S_IDLE) || r_done);
    w_tout_err = (r_tout_err & ~{NB{bus.err_clr}}) | w_err_set;
    w_overrun  = (r_overrun & ~bus.err_clr) | w_ovr_set;
    w_busy     = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_sh_trm   <= TRM_IV;
      r_sh_wait  <= '0;
      r_trm      <= TRM_IV;
      r_wait     <= '0;
      r_qreq     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tout_err <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_cnt      <= w_cnt;
      r_sh_trm   <= w_sh_trm;
      r_sh_wait  <= w_sh_wait;
      r_trm      <= w_trm;
      r_wait     <= w_wait;
      r_qreq     <= w_qreq;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_tout_err <= w_tout_err;
      r_overrun  <= w_overrun;
    end
  end

  assign bus.qreq     = r_qreq;
  assign bus.trm_out  = r_trm;
  assign bus.wait_out = r_wait;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.tout_err = r_tout_err;
  assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_coresub_sramtrm_seq.sv
// Randomized bench for coresub_sramtrm_seq: a bank-level model predicts applied values,
// error flags and sequence length; a delayed-echo responder plays the SRAM quiesce ack.
module tb_coresub_sramtrm_seq;

  localparam int unsigned      NB     = 6;
  localparam int unsigned      TW     = 3;
  localparam int unsigned      WW     = 2;
  localparam int unsigned      SETTLE = 8;
  localparam int unsigned      TOUT   = 255;
  localparam logic [NB*TW-1:0] TRM_IV = 18'o344244;

  logic clk = 1'b0;
  logic resetn;

  coresub_sramtrm_seq_if #(.NB(NB), .TW(TW), .WW(WW)) bus ();

  coresub_sramtrm_seq #(
    .NB(NB), .TW(TW), .WW(WW), .TRM_IV(TRM_IV), .SETTLE(SETTLE), .TOUT(TOUT)
  ) u_dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bank-level reference state
  logic [TW-1:0] m_trm  [NB];
  logic [WW-1:0] m_wait [NB];
  logic [NB-1:0] m_err;
  logic          m_ovr;

  function automatic logic [NB*TW-1:0] m_trm_flat();
    logic [NB*TW-1:0] v;
    for (int b = 0; b < NB; b++) v[b*TW +: TW] = m_trm[b];
    return v;
  endfunction

  function automatic logic [NB*WW-1:0] m_wait_flat();
    logic [NB*WW-1:0] v;
    for (int b = 0; b < NB; b++) v[b*WW +: WW] = m_wait[b];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_trm[b]  = TRM_IV[b*TW +: TW];
      m_wait[b] = '0;
    end
    m_err = '0;
    m_ovr = 1'b0;
  endtask

  // Ack responder: qack echoes qreq after ack_dly cycles unless the bank is stuck low
  int unsigned   ack_dly = 0;
  logic [NB-1:0] stuck   = '0;
  logic [7:0]    hist [NB] = '{default: '0};

  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      hist[b]     = {hist[b][6:0], bus.qreq[b]};
      bus.qack[b] = stuck[b] ? 1'b0 : hist[b][ack_dly];
    end
  end

  // Cycle monitor: one quiesce at a time, outputs move only on a quiesced bank
  logic [NB*TW-1:0] p_trm;
  logic [NB*WW-1:0] p_wait;
  bit               p_ok = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      p_ok = 1'b0;
    end else begin
      chk("qreq_onehot0", 32'($countones(bus.qreq) <= 1), 32'd1);
      if (p_ok) begin
        for (int b = 0; b < NB; b++) begin
          if ((bus.trm_out[b*TW +: TW] != p_trm[b*TW +: TW]) ||
              (bus.wait_out[b*WW +: WW] != p_wait[b*WW +: WW]))
            chk("chg_under_quiesce", 32'({bus.qreq[b], bus.qack[b]}), 32'b11);
        end
      end
      p_trm  = bus.trm_out;
      p_wait = bus.wait_out;
      p_ok   = 1'b1;
    end
  end

  task automatic chk_state(input string tag);
    chk({tag, "_trm"},  32'(bus.trm_out),  32'(m_trm_flat()));
    chk({tag, "_wait"}, 32'(bus.wait_out), 32'(m_wait_flat()));
    chk({tag, "_err"},  32'(bus.tout_err), 32'(m_err));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_trm"},  32'(bus.trm_out),  32'(TRM_IV));
    chk({tag, "_wait"}, 32'(bus.wait_out), 32'd0);
    chk({tag, "_qreq"}, 32'(bus.qreq),     32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),     32'd0);
    chk({tag, "_done"}, 32'(bus.done),     32'd0);
    chk({tag, "_err"},  32'(bus.tout_err), 32'd0);
    chk({tag, "_ovr"},  32'(bus.overrun),  32'd0);
  endtask

  // One full apply sequence with prediction of length, touched banks and final state
  task automatic run_seq(input logic [NB*TW-1:0] tt, input logic [NB*WW-1:0] tw,
                         input int unsigned dly, input logic [NB-1:0] stk,
                         input bit inj_ovr, input bit at_done, input bit clr_on_tout);
    int            exp_cyc;
    int            cyc;
    int            guard;
    int            qhi;
    logic [NB-1:0] chg;
    logic [NB-1:0] seen;
    ack_dly = dly;
    stuck   = stk;
    bus.tgt_trm  = tt;
    bus.tgt_wait = tw;
    exp_cyc = 0;
    chg     = '0;
    for (int b = 0; b < NB; b++) begin
      chg[b] = (tt[b*TW +: TW] != m_trm[b]) || (tw[b*WW +: WW] != m_wait[b]);
      if (!chg[b]) begin
        exp_cyc += 1;
      end else if (stk[b]) begin
        exp_cyc += 1 + int'(TOUT);
        m_err[b] = 1'b1;
      end else begin
        exp_cyc += 4 + int'(SETTLE) + 2 * int'(dly);
        m_trm[b]  = tt[b*TW +: TW];
        m_wait[b] = tw[b*WW +: WW];
      end
    end
    @(negedge clk) bus.apply = 1'b1;
    @(negedge clk) bus.apply = 1'b0;
    cyc = 0; guard = 0; qhi = 0; seen = '0;
    while (!bus.done && guard < exp_cyc + 600) begin
      if (bus.busy) cyc++;
      seen |= bus.qreq;
      if (cyc == 2) begin
        bus.tgt_trm  = (NB*TW)'({$urandom, $urandom});
        bus.tgt_wait = (NB*WW)'($urandom);
        bus.apply    = inj_ovr;
        if (inj_ovr) m_ovr = 1'b1;
      end else begin
        bus.apply = 1'b0;
      end
      if (clr_on_tout) begin
        if (|(bus.qreq & stk)) qhi++;
        bus.err_clr = (qhi == int'(TOUT)) && (|(bus.qreq & stk));
      end
      guard++;
      @(negedge clk);
    end
    bus.err_clr = 1'b0;
    if (clr_on_tout) begin
      m_err = stk & chg;
      m_ovr = 1'b0;
    end
    chk("done_seen",   32'(bus.done), 32'd1);
    chk("busy_cycles", 32'(cyc),      32'(exp_cyc));
    chk("qreq_banks",  32'(seen),     32'(chg));
    chk_state("seq");
    bus.apply = at_done;
    if (at_done) m_ovr = 1'b1;
    @(negedge clk);
    bus.apply = 1'b0;
    chk("done_pulse", 32'(bus.done),    32'd0);
    chk("post_busy",  32'(bus.busy),    32'd0);
    chk("ovr",        32'(bus.overrun), 32'(m_ovr));
    repeat (ack_dly + 2) @(negedge clk);
  endtask

  task automatic clr_errs();
    @(negedge clk) bus.err_clr = 1'b1;
    @(negedge clk) bus.err_clr = 1'b0;
    m_err = '0;
    m_ovr = 1'b0;
    chk("clr_err", 32'(bus.tout_err), 32'd0);
    chk("clr_ovr", 32'(bus.overrun),  32'd0);
  endtask

  logic [NB*TW-1:0] tt;
  logic [NB*WW-1:0] tw;
  int               guard;

  initial begin
    resetn       = 1'b1;
    bus.apply    = 1'b0;
    bus.err_clr  = 1'b0;
    bus.tgt_trm  = TRM_IV;
    bus.tgt_wait = '0;
    model_reset();

    // Reset takes effect asynchronously
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset("rst");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // No-change apply
    run_seq(TRM_IV, '0, 0, '0, 1'b0, 1'b0, 1'b0);

    // Single bank 3 -> 5 with 2-cycle ack
    tt = m_trm_flat();
    tt[3*TW +: TW] = 3'h5;
    run_seq(tt, m_wait_flat(), 2, '0, 1'b0, 1'b0, 1'b0);

    // Bank 1 ack stuck low
    tt = m_trm_flat();
    tt[1*TW +: TW] = ~m_trm[1];
    run_seq(tt, m_wait_flat(), 1, 6'b000010, 1'b0, 1'b0, 1'b0);

    // Overrun while busy and on the done cycle, then clear
    tt = m_trm_flat();
    tw = m_wait_flat();
    tw[0*WW +: WW] = ~m_wait[0];
    run_seq(tt, tw, 0, '0, 1'b1, 1'b1, 1'b0);
    clr_errs();

    // err_clr landing on the same edge as a new timeout
    tt = m_trm_flat();
    tt[4*TW +: TW] = ~m_trm[4];
    run_seq(tt, m_wait_flat(), 0, 6'b010000, 1'b1, 1'b0, 1'b1);
    clr_errs();

    // Reset while a bank is settling
    ack_dly = 1;
    stuck   = '0;
    tt = m_trm_flat();
    tt[2*TW +: TW] = ~m_trm[2];
    bus.tgt_trm = tt;
    @(negedge clk) bus.apply = 1'b1;
    @(negedge clk) bus.apply = 1'b0;
    guard = 0;
    while (bus.trm_out == m_trm_flat() && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    chk("settle_reached", 32'(bus.trm_out[2*TW +: TW]), 32'(tt[2*TW +: TW]));
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1 chk_reset("mid_rst");
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    run_seq(tt, m_wait_flat(), 1, '0, 1'b0, 1'b0, 1'b0);

    // Randomized sequences
    for (int n = 0; n < 30; n++) begin
      logic [NB-1:0] stk;
      for (int b = 0; b < NB; b++) begin
        tt[b*TW +: TW] = ($urandom_range(1, 0) == 1) ? m_trm[b]  : TW'($urandom);
        tw[b*WW +: WW] = ($urandom_range(1, 0) == 1) ? m_wait[b] : WW'($urandom);
      end
      stk = '0;
      if ($urandom_range(5, 0) == 0) stk[$urandom_range(NB-1, 0)] = 1'b1;
      run_seq(tt, tw, $urandom_range(3, 0), stk,
              1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0), 1'b0);
      if ($urandom_range(3, 0) == 0) clr_errs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
